// File: rtl/linear_pkg.sv
// Shared types and defaults for the quantized linear layer datapath.
package linear_pkg;

   typedef enum logic {
      LOAD   = 1'b0,
      REPLAY = 1'b1
   } state_t;

   localparam int unsigned PRECISION_DEF      = 8;
   localparam int unsigned BIAS_PRECISION_DEF = 32;
   localparam int unsigned IN_FEATURES_DEF    = 16;
   localparam int unsigned OUT_NEURONS_DEF    = 4;

   // Counter widths for the default geometry; modules recompute for overrides.
   localparam int unsigned CNT_W  = $clog2(IN_FEATURES_DEF) + 1;
   localparam int unsigned PASS_W = $clog2(OUT_NEURONS_DEF) + 1;

endpackage

// File: rtl/vector_buffer.sv
// Activation vector store: one write port, registered-address read port.
module vector_buffer #(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] raddr_q;

   // Storage array; contents are don't-care after reset.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Read address register so rdata comes purely from flops.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) raddr_q <= '0;
      else      raddr_q <= raddr;
   end

   assign rdata = mem[raddr_q];

endmodule

// File: rtl/input_stage.sv
// Buffers one activation vector, sums it into ai, and replays it once per
// output neuron to the MAC datapath.
module input_stage
   import linear_pkg::*;
#(
   parameter int unsigned PRECISION      = PRECISION_DEF,
   parameter int unsigned IN_FEATURES    = IN_FEATURES_DEF,
   parameter int unsigned OUT_NEURONS    = OUT_NEURONS_DEF,
   parameter int unsigned BIAS_PRECISION = BIAS_PRECISION_DEF
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               s_valid,
   output logic                               s_ready,
   input  logic [PRECISION-1:0]               s_data,
   output logic                               m_valid,
   input  logic                               m_ready,
   output logic [PRECISION-1:0]               m_data,
   output logic                               m_last,
   output logic [$clog2(OUT_NEURONS+0)+1-1:0] m_neuron,
   output logic [BIAS_PRECISION-1:0]          ai,
   output logic                               ai_valid,
   output logic                               busy
);

   localparam int unsigned CW = $clog2(IN_FEATURES) + 1;
   localparam int unsigned PW = $clog2(OUT_NEURONS) + 1;
   localparam int unsigned AW = $clog2(IN_FEATURES);

   state_t                    state, state_nxt;
   logic [CW-1:0]             elem_cnt, elem_nxt;
   logic [PW-1:0]             pass_cnt, pass_nxt;
   logic [BIAS_PRECISION-1:0] sum, sum_nxt;
   logic                      we;
   logic                      s_fire, m_fire;
   logic                      elem_last, pass_last;

   logic                      s_ready_d, m_valid_d, m_last_d, ai_valid_d, busy_d;
   logic [PW-1:0]             m_neuron_d;
   logic [BIAS_PRECISION-1:0] ai_d;

   assign s_fire    = s_valid & s_ready;
   assign m_fire    = m_valid & m_ready;
   assign elem_last = (elem_cnt == CW'(IN_FEATURES - 1));
   assign pass_last = (pass_cnt == PW'(OUT_NEURONS - 1));

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= LOAD;
      else      state <= state_nxt;
   end

   // Next state, counters, running sum and buffer write enable.
   always_comb begin
      state_nxt = state;
      elem_nxt  = elem_cnt;
      pass_nxt  = pass_cnt;
      sum_nxt   = sum;
      we        = 1'b0;
      case (state)
         LOAD: begin
            if (s_fire) begin
               we      = 1'b1;
               // First element restarts the sum so vectors never accumulate.
               sum_nxt = (elem_cnt == '0) ? BIAS_PRECISION'(s_data)
                                          : sum + BIAS_PRECISION'(s_data);
               if (elem_last) begin
                  elem_nxt  = '0;
                  pass_nxt  = '0;
                  state_nxt = REPLAY;
               end else begin
                  elem_nxt = elem_cnt + CW'(1);
               end
            end
         end
         REPLAY: begin
            if (m_fire) begin
               if (elem_last) begin
                  elem_nxt = '0;
                  if (pass_last) begin
                     pass_nxt  = '0;
                     state_nxt = LOAD;
                  end else begin
                     pass_nxt = pass_cnt + PW'(1);
                  end
               end else begin
                  elem_nxt = elem_cnt + CW'(1);
               end
            end
         end
         default: state_nxt = LOAD;
      endcase
   end

   // Next values of the registered outputs, all derived from the next state.
   always_comb begin
      s_ready_d  = 1'b0;
      m_valid_d  = 1'b0;
      m_last_d   = 1'b0;
      m_neuron_d = '0;
      ai_d       = '0;
      ai_valid_d = 1'b0;
      busy_d     = (state_nxt != LOAD) || (elem_nxt != '0);
      if (state_nxt == REPLAY) begin
         m_valid_d  = 1'b1;
         m_last_d   = (elem_nxt == CW'(IN_FEATURES - 1));
         m_neuron_d = pass_nxt;
         ai_d       = sum_nxt;
         ai_valid_d = 1'b1;
      end else begin
         s_ready_d = 1'b1;
      end
   end

   // Counter, sum and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         elem_cnt <= '0;
         pass_cnt <= '0;
         sum      <= '0;
         s_ready  <= 1'b0;
         m_valid  <= 1'b0;
         m_last   <= 1'b0;
         m_neuron <= '0;
         ai       <= '0;
         ai_valid <= 1'b0;
         busy     <= 1'b0;
      end else begin
         elem_cnt <= elem_nxt;
         pass_cnt <= pass_nxt;
         sum      <= sum_nxt;
         s_ready  <= s_ready_d;
         m_valid  <= m_valid_d;
         m_last   <= m_last_d;
         m_neuron <= m_neuron_d;
         ai       <= ai_d;
         ai_valid <= ai_valid_d;
         busy     <= busy_d;
      end
   end

   vector_buffer #(
      .W     (PRECISION),
      .DEPTH (IN_FEATURES),
      .AW    (AW)
   ) u_buf (
      .clk   (clk),
      .rst   (rst),
      .we    (we),
      .waddr (AW'(elem_cnt)),
      .wdata (s_data),
      .raddr (AW'(elem_nxt)),
      .rdata (m_data)
   );

endmodule

// File: tb/tb_input_stage.sv
// Directed and randomized checks of input_stage with a 4-element, 2-pass geometry.
module tb_input_stage;

   localparam int unsigned IN_F = 4;
   localparam int unsigned OUT_N = 2;
   localparam int unsigned P = 8;
   localparam int unsigned BP = 32;
   localparam int unsigned NW = $clog2(OUT_N) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [P-1:0]  s_data = '0;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [P-1:0]  m_data;
   logic          m_last;
   logic [NW-1:0] m_neuron;
   logic [BP-1:0] ai;
   logic          ai_valid;
   logic          busy;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   input_stage #(
      .PRECISION      (P),
      .IN_FEATURES    (IN_F),
      .OUT_NEURONS    (OUT_N),
      .BIAS_PRECISION (BP)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .s_valid  (s_valid),
      .s_ready  (s_ready),
      .s_data   (s_data),
      .m_valid  (m_valid),
      .m_ready  (m_ready),
      .m_data   (m_data),
      .m_last   (m_last),
      .m_neuron (m_neuron),
      .ai       (ai),
      .ai_valid (ai_valid),
      .busy     (busy)
   );

   // Observation bundle: {m_valid, ai_valid, m_last, m_neuron, m_data, ai}
   function automatic logic [44:0] obs();
      return {m_valid, ai_valid, m_last, m_neuron, m_data, ai};
   endfunction

   function automatic logic [44:0] beat_exp(input logic [31:0] v, input int beat, input logic [31:0] s);
      logic [7:0] d;
      d = v[8*(beat % 4) +: 8];
      return {1'b1, 1'b1, (beat % 4) == 3, NW'(beat / 4), d, s};
   endfunction

   // Feed four elements back-to-back; called at a negedge in LOAD.
   task automatic load_vec(input logic [31:0] v);
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1;
         s_data  = v[8*i +: 8];
         @(negedge clk);
      end
      s_valid = 1'b0;
   endtask

   // Replay nbeats with m_ready high; sv is driven on s_valid with 0xAA data.
   task automatic replay_check(input string nm, input logic [31:0] v, input logic [31:0] s,
                               input int nbeats, input logic sv);
      logic [44:0] e;
      m_ready = 1'b1;
      s_valid = sv;
      s_data  = 8'hAA;
      for (int b = 0; b < nbeats; b++) begin
         e = beat_exp(v, b, s);
         n_cmp++;
         if (obs() !== e) begin
            n_err++;
            $display("FAIL %s beat %0d: got %h want %h", nm, b, obs(), e);
         end
         n_cmp++;
         if (s_ready !== 1'b0) begin
            n_err++;
            $display("FAIL %s s_ready in replay beat %0d: got %b want 0", nm, b, s_ready);
         end
         @(negedge clk);
      end
      m_ready = 1'b0;
      s_valid = 1'b0;
      if (nbeats == 8) begin
         n_cmp++;
         if ({s_ready, m_valid, ai_valid, busy} !== 4'b1000) begin
            n_err++;
            $display("FAIL %s end-of-replay {s_ready,m_valid,ai_valid,busy}: got %b want 1000",
                     nm, {s_ready, m_valid, ai_valid, busy});
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({s_ready, m_valid, m_last, m_neuron, ai, ai_valid, busy} !== '0) begin
         n_err++;
         $display("FAIL reset_hold: got s_ready=%b m_valid=%b m_last=%b m_neuron=%0d ai=%0d ai_valid=%b busy=%b want all 0",
                  s_ready, m_valid, m_last, m_neuron, ai, ai_valid, busy);
      end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({s_ready, m_valid, ai_valid, busy} !== 4'b1000) begin
         n_err++;
         $display("FAIL reset_release {s_ready,m_valid,ai_valid,busy}: got %b want 1000",
                  {s_ready, m_valid, ai_valid, busy});
      end
   endtask

   task automatic test_basic();
      s_valid = 1'b1;
      s_data  = 8'd10;
      @(negedge clk);
      n_cmp++;
      if ({busy, s_ready, m_valid} !== 3'b110) begin
         n_err++;
         $display("FAIL basic_mid_load {busy,s_ready,m_valid}: got %b want 110", {busy, s_ready, m_valid});
      end
      for (int i = 1; i < 4; i++) begin
         s_data = 8'(10 * (i + 1));
         @(negedge clk);
      end
      s_valid = 1'b0;
      replay_check("basic", {8'd40, 8'd30, 8'd20, 8'd10}, 32'd100, 8, 1'b0);
   endtask

   task automatic test_overflow();
      load_vec({4{8'd255}});
      replay_check("max_sum", {4{8'd255}}, 32'd1020, 8, 1'b0);
      load_vec({4{8'd1}});
      replay_check("sum_restart", {4{8'd1}}, 32'd4, 8, 1'b0);
   endtask

   task automatic test_ignore();
      load_vec({8'd4, 8'd3, 8'd2, 8'd1});
      replay_check("ignore_s", {8'd4, 8'd3, 8'd2, 8'd1}, 32'd10, 8, 1'b1);
   endtask

   task automatic test_reset_mid_load();
      s_valid = 1'b1;
      s_data  = 8'd99;
      repeat (2) @(negedge clk);
      s_valid = 1'b0;
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({m_valid, ai_valid, busy, ai} !== '0) begin
         n_err++;
         $display("FAIL rst_mid_load: got m_valid=%b ai_valid=%b busy=%b ai=%0d want 0",
                  m_valid, ai_valid, busy, ai);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      load_vec({8'd8, 8'd7, 8'd6, 8'd5});
      replay_check("after_rst_load", {8'd8, 8'd7, 8'd6, 8'd5}, 32'd26, 8, 1'b0);
   endtask

   task automatic test_reset_mid_replay();
      load_vec({8'd40, 8'd30, 8'd20, 8'd10});
      replay_check("pre_rst_replay", {8'd40, 8'd30, 8'd20, 8'd10}, 32'd100, 5, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({m_valid, ai_valid} !== 2'b00) begin
         n_err++;
         $display("FAIL rst_mid_replay async: got m_valid=%b ai_valid=%b want 0 0", m_valid, ai_valid);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({s_ready, m_valid, busy} !== 3'b100) begin
         n_err++;
         $display("FAIL rst_mid_replay release {s_ready,m_valid,busy}: got %b want 100",
                  {s_ready, m_valid, busy});
      end
      load_vec({8'd8, 8'd7, 8'd6, 8'd5});
      replay_check("after_rst_replay", {8'd8, 8'd7, 8'd6, 8'd5}, 32'd26, 8, 1'b0);
   endtask

   task automatic test_random();
      logic [31:0] rvec [20];
      logic [31:0] rsum [20];
      logic [44:0] prev, e;
      int  ld = 0, lidx = 0, rp = 0, beat = 0, cyc = 0;
      bit  rep = 1'b0, stall = 1'b0, was_rep;
      for (int v = 0; v < 20; v++) begin
         rvec[v] = $urandom;
         rsum[v] = 32'(rvec[v][7:0]) + 32'(rvec[v][15:8]) + 32'(rvec[v][23:16]) + 32'(rvec[v][31:24]);
      end
      while (rp < 20 && cyc < 3000) begin
         n_cmp++;
         if ({s_ready, m_valid, ai_valid} !== {!rep, rep, rep}) begin
            n_err++;
            $display("FAIL rand cyc %0d {s_ready,m_valid,ai_valid}: got %b want %b",
                     cyc, {s_ready, m_valid, ai_valid}, {!rep, rep, rep});
         end
         if (rep) begin
            e = beat_exp(rvec[rp], beat, rsum[rp]);
            n_cmp++;
            if (obs() !== e) begin
               n_err++;
               $display("FAIL rand vec %0d beat %0d: got %h want %h", rp, beat, obs(), e);
            end
            if (stall) begin
               n_cmp++;
               if (obs() !== prev) begin
                  n_err++;
                  $display("FAIL rand stall_hold vec %0d beat %0d: got %h want %h", rp, beat, obs(), prev);
               end
            end
         end
         prev    = obs();
         was_rep = rep;
         m_ready = 1'($urandom_range(0, 1));
         s_valid = 1'($urandom_range(0, 1));
         s_data  = rep ? 8'hAA : rvec[ld][8*lidx +: 8];
         if (rep && m_ready) begin
            beat++;
            if (beat == 8) begin
               beat = 0;
               rp++;
               rep = 1'b0;
            end
         end else if (!rep && s_valid) begin
            lidx++;
            if (lidx == 4) begin
               lidx = 0;
               ld++;
               rep = 1'b1;
            end
         end
         stall = was_rep && !m_ready;
         @(negedge clk);
         cyc++;
      end
      m_ready = 1'b0;
      s_valid = 1'b0;
      n_cmp++;
      if (rp != 20) begin
         n_err++;
         $display("FAIL rand timeout: got %0d vectors replayed want 20", rp);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_ignore();
      test_random();
      test_reset_mid_load();
      test_reset_mid_replay();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
